mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 106 ++++++++++
 tb/tb_mem_access_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit between pipeline and byte-addressed data memory.
// Optional MEM_MISALIGN_TRAP_EN rejects misaligned half/word accesses without touching memory.
module mem_access_unit #(
  parameter int NUM_BITS  = 32,
  parameter int NUM_DIREC = 7
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [NUM_DIREC-1:0]  i_req_addr,
  input  logic [NUM_BITS-1:0]   i_req_wdata,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [NUM_BITS-1:0]   o_resp_rdata,
  output logic                  o_misalign,
  output logic                  o_wr_protect,
  output logic                  o_mem_write_enable,
  output logic [NUM_BITS/8-1:0] o_mem_byte_enb,
  output logic [NUM_DIREC-1:0]  o_mem_direcc,
  output logic [NUM_BITS-1:0]   o_mem_data,
  input  logic [NUM_BITS-1:0]   i_mem_data
);
  localparam int NB = NUM_BITS / 8;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, uns_q, uns_d, mis_q, mis_d, wp_q, wp_d;
  logic [1:0] size_q, size_d;
  logic [NUM_DIREC-1:0] addr_q, addr_d;
  logic [NUM_BITS-1:0] wdata_q, wdata_d, rdata_q, rdata_d, load_ext;
  logic misaligned, access;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = (i_req_size == 2'b01 && i_req_addr[0]) || (i_req_size[1] && i_req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif
  assign load_ext = size_q[1] ? i_mem_data :
                    size_q[0] ? {{(NUM_BITS-16){!uns_q && i_mem_data[15]}}, i_mem_data[15:0]} :
                                {{(NUM_BITS-8){!uns_q && i_mem_data[7]}}, i_mem_data[7:0]};
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    wp_d    = wp_q;
    if (state_q == IDLE && i_req_valid) begin
      we_d    = i_req_we;
      size_d  = i_req_size;
      uns_d   = i_req_unsigned;
      addr_d  = i_req_addr;
      wdata_d = i_req_wdata;
      rdata_d = '0;
      mis_d   = misaligned;
      wp_d    = 1'b0;
      state_d = misaligned ? RESP : ACCESS;
    end
    if (state_q == ACCESS) begin
      rdata_d = we_q ? '0 : load_ext;
      mis_d   = 1'b0;
      wp_d    = we_q && addr_q < NUM_DIREC'(4);
      state_d = RESP;
    end
    if (state_q == RESP && i_resp_ready) state_d = IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      wp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      wp_q    <= wp_d;
    end
  end
  // Gating with i_reset kills the strobe in the very cycle an abort arrives.
  assign access             = state_q == ACCESS && !i_reset;
  assign o_req_ready        = state_q == IDLE;
  assign o_resp_valid       = state_q == RESP;
  assign o_resp_rdata       = rdata_q;
  assign o_misalign         = mis_q;
  assign o_wr_protect       = wp_q;
  assign o_mem_write_enable = access && we_q;
  assign o_mem_byte_enb     = !access ? '0 : size_q[1] ? '1 : size_q[0] ? NB'(3) : NB'(1);
  assign o_mem_direcc       = addr_q;
  assign o_mem_data         = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scenario tasks with an expected-response queue for mem_access_unit.
module tb_mem_access_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic i_reset = 1'b1, i_req_valid = 1'b0, i_req_we = 1'b0, i_req_unsigned = 1'b0, i_resp_ready = 1'b0;
  logic [1:0] i_req_size = '0;
  logic [6:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0, i_mem_data = '0;
  logic o_req_ready, o_resp_valid, o_misalign, o_wr_protect, o_mem_write_enable;
  logic [31:0] o_resp_rdata, o_mem_data;
  logic [3:0] o_mem_byte_enb;
  logic [6:0] o_mem_direcc;

  mem_access_unit #(.NUM_BITS(32), .NUM_DIREC(7)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .o_resp_valid(o_resp_valid),
    .i_resp_ready(i_resp_ready), .o_resp_rdata(o_resp_rdata), .o_misalign(o_misalign),
    .o_wr_protect(o_wr_protect), .o_mem_write_enable(o_mem_write_enable),
    .o_mem_byte_enb(o_mem_byte_enb), .o_mem_direcc(o_mem_direcc), .o_mem_data(o_mem_data),
    .i_mem_data(i_mem_data)
  );

  typedef struct {logic [31:0] rdata; logic mis; logic wp;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, wcount = 0, last_accept = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (o_mem_write_enable) wcount++;

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] ext(input logic [1:0] size, input logic uns, input logic [31:0] d);
    if (size[1]) return d;
    if (size[0]) return uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
    return uns ? {24'h0, d[7:0]} : {{24{d[7]}}, d[7:0]};
  endfunction

  task automatic access(input logic we, input logic [1:0] size, input logic uns, input logic [6:0] addr,
                        input logic [31:0] wdata, input logic [31:0] mem, input logic [3:0] exp_enb,
                        input logic [31:0] exp_rdata, input logic exp_wp, input logic exp_mis, input int hold);
    exp_t e;
    logic [31:0] held;
    int w0;
    @(negedge clk);
    total++;
    if (o_req_ready !== 1'b1) begin bad++; $display("FAIL req_ready_idle got=%b want=1", o_req_ready); end
    last_accept = cyc;
    w0 = wcount;
    i_req_valid = 1'b1; i_req_we = we; i_req_size = size; i_req_unsigned = uns;
    i_req_addr = addr; i_req_wdata = wdata; i_mem_data = mem; i_resp_ready = 1'b0;
    sb.push_back('{exp_rdata, exp_mis, exp_wp});
    @(negedge clk);
    i_req_valid = 1'b0; i_req_we = ~we; i_req_size = ~size; i_req_addr = ~addr; i_req_wdata = ~wdata;
    if (!exp_mis) begin
      total++;
      if ({o_resp_valid, o_mem_write_enable, o_mem_byte_enb, o_mem_direcc} !== {1'b0, we, exp_enb, addr}) begin
        bad++;
        $display("FAIL access_phase got v=%b we=%b enb=%b a=%h want v=0 we=%b enb=%b a=%h",
                 o_resp_valid, o_mem_write_enable, o_mem_byte_enb, o_mem_direcc, we, exp_enb, addr);
      end
      total++;
      if (o_mem_data !== wdata) begin bad++; $display("FAIL mem_data got=%h want=%h", o_mem_data, wdata); end
      @(negedge clk);
    end
    total++;
    if ({o_resp_valid, o_mem_write_enable, o_mem_byte_enb, o_req_ready} !== 7'b1_0_0000_0) begin
      bad++;
      $display("FAIL resp_latency got v=%b we=%b enb=%b rdy=%b want v=1 we=0 enb=0 rdy=0",
               o_resp_valid, o_mem_write_enable, o_mem_byte_enb, o_req_ready);
    end
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL scoreboard_empty got=0 want=1"); end
    else begin
      e = sb.pop_front();
      if ({o_resp_rdata, o_misalign, o_wr_protect} !== {e.rdata, e.mis, e.wp}) begin
        bad++;
        $display("FAIL resp_fields got rdata=%h mis=%b wp=%b want rdata=%h mis=%b wp=%b",
                 o_resp_rdata, o_misalign, o_wr_protect, e.rdata, e.mis, e.wp);
      end
    end
    total++;
    if (wcount - w0 !== ((we && !exp_mis) ? 1 : 0)) begin
      bad++; $display("FAIL strobe_count got=%0d want=%0d", wcount - w0, (we && !exp_mis) ? 1 : 0);
    end
    held = o_resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total++;
      if ({o_resp_valid, o_req_ready, o_resp_rdata} !== {1'b1, 1'b0, held}) begin
        bad++;
        $display("FAIL resp_hold cyc=%0d got v=%b rdy=%b rdata=%h want v=1 rdy=0 rdata=%h",
                 i, o_resp_valid, o_req_ready, o_resp_rdata, held);
      end
    end
    i_resp_ready = 1'b1;
    @(posedge clk);
    #1 i_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 7'h10;
    repeat (3) @(negedge clk);
    total++;
    if ({o_req_ready, o_resp_valid, o_resp_rdata, o_misalign, o_wr_protect, o_mem_write_enable,
         o_mem_byte_enb, o_mem_direcc, o_mem_data} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 7'h0, 32'h0}) begin
      bad++;
      $display("FAIL reset_state got rdy=%b v=%b rd=%h mis=%b wp=%b we=%b enb=%b a=%h d=%h want 1/0/0...",
               o_req_ready, o_resp_valid, o_resp_rdata, o_misalign, o_wr_protect, o_mem_write_enable,
               o_mem_byte_enb, o_mem_direcc, o_mem_data);
    end
    i_req_valid = 1'b0; i_reset = 1'b0;
  endtask

  task automatic test_store_word();
    access(1'b1, 2'b10, 1'b0, 7'h10, 32'hDEADBEEF, 32'h0, 4'b1111, 32'h0, 1'b0, 1'b0, 0);
    access(1'b1, 2'b01, 1'b0, 7'h22, 32'h0000A5A5, 32'hFFFFFFFF, 4'b0011, 32'h0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_loads();
    access(1'b0, 2'b00, 1'b0, 7'h11, 32'h0, 32'h00000080, 4'b0001, 32'hFFFFFF80, 1'b0, 1'b0, 0);
    access(1'b0, 2'b00, 1'b1, 7'h11, 32'h0, 32'h00000080, 4'b0001, 32'h00000080, 1'b0, 1'b0, 0);
    access(1'b0, 2'b01, 1'b0, 7'h10, 32'h0, 32'h00008001, 4'b0011, 32'hFFFF8001, 1'b0, 1'b0, 0);
    access(1'b0, 2'b01, 1'b1, 7'h12, 32'h0, 32'hFFFF8001, 4'b0011, 32'h00008001, 1'b0, 1'b0, 0);
    access(1'b0, 2'b00, 1'b0, 7'h05, 32'h0, 32'hFFFFFF7F, 4'b0001, 32'h0000007F, 1'b0, 1'b0, 0);
    access(1'b0, 2'b10, 1'b0, 7'h14, 32'h0, 32'h12345678, 4'b1111, 32'h12345678, 1'b0, 1'b0, 0);
  endtask

  task automatic test_wr_protect();
    access(1'b1, 2'b00, 1'b0, 7'h02, 32'h000000AB, 32'h0, 4'b0001, 32'h0, 1'b1, 1'b0, 0);
    access(1'b0, 2'b00, 1'b0, 7'h02, 32'h0, 32'h00000011, 4'b0001, 32'h00000011, 1'b0, 1'b0, 0);
    access(1'b1, 2'b00, 1'b0, 7'h04, 32'h000000CD, 32'h0, 4'b0001, 32'h0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    int a0;
    access(1'b0, 2'b10, 1'b0, 7'h18, 32'h0, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b0, 5);
    a0 = last_accept;
    access(1'b0, 2'b00, 1'b1, 7'h19, 32'h0, 32'h000000F0, 4'b0001, 32'h000000F0, 1'b0, 1'b0, 0);
    total++;
    if (last_accept - a0 !== 8) begin bad++; $display("FAIL release_accept got=%0d want=8", last_accept - a0); end
  endtask

  task automatic test_back_to_back();
    int a0;
    access(1'b1, 2'b10, 1'b0, 7'h40, 32'h11111111, 32'h0, 4'b1111, 32'h0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      logic we, uns;
      logic [1:0] size;
      logic [6:0] addr;
      logic [31:0] wd, md;
      a0 = last_accept;
      we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 2)); wd = $urandom; md = $urandom;
      addr = 7'($urandom_range(0, 127));
      addr = size[1] ? {addr[6:2], 2'b00} : size[0] ? {addr[6:1], 1'b0} : addr;
      access(we, size, uns, addr, wd, md, size[1] ? 4'b1111 : size[0] ? 4'b0011 : 4'b0001,
             we ? 32'h0 : ext(size, uns, md), we && addr < 7'd4, 1'b0, 0);
      total++;
      if (last_accept - a0 !== 3) begin bad++; $display("FAIL throughput got=%0d want=3", last_accept - a0); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'b10; i_req_addr = 7'h30; i_req_wdata = 32'h55AA55AA;
    @(negedge clk);
    i_req_valid = 1'b0;
    total++;
    if (o_mem_write_enable !== 1'b1) begin bad++; $display("FAIL abort_pre got we=%b want=1", o_mem_write_enable); end
    i_reset = 1'b1;
    #1;
    total++;
    if (o_mem_write_enable !== 1'b0) begin bad++; $display("FAIL abort_strobe got we=%b want=0", o_mem_write_enable); end
    @(negedge clk);
    i_reset = 1'b0;
    total++;
    if ({o_req_ready, o_resp_valid, o_mem_direcc} !== {1'b1, 1'b0, 7'h0}) begin
      bad++; $display("FAIL abort_idle got rdy=%b v=%b a=%h want rdy=1 v=0 a=00", o_req_ready, o_resp_valid, o_mem_direcc);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL abort_noresp got=%b want=0", o_resp_valid); end
    end
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    access(1'b0, 2'b10, 1'b0, 7'h13, 32'h0, 32'h87654321, 4'b0000, 32'h0, 1'b0, 1'b1, 0);
    access(1'b1, 2'b01, 1'b0, 7'h21, 32'h0000BEEF, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1, 0);
`else
    access(1'b0, 2'b10, 1'b0, 7'h13, 32'h0, 32'h87654321, 4'b1111, 32'h87654321, 1'b0, 1'b0, 0);
    access(1'b1, 2'b01, 1'b0, 7'h21, 32'h0000BEEF, 32'h0, 4'b0011, 32'h0, 1'b0, 1'b0, 0);
`endif
    access(1'b0, 2'b01, 1'b0, 7'h22, 32'h0, 32'h00007FFF, 4'b0011, 32'h00007FFF, 1'b0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_loads();
    test_wr_protect();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
